// File: rtl/demux_1to8_frame.sv
// demux_1to8_frame: steers valid/ready words into 8 lane registers and presents
// the full frame on out_data until the consumer acknowledges it.
module demux_1to8_frame #(
  parameter int DATA_W = 3,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [2:0]              in_sel,
  input  logic                    seq_mode,
  input  logic                    clr,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        lane_mask,
  output logic [2:0]              slot,
  output logic                    frame_valid,
  input  logic                    frame_ready
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t                    state_q, state_d;
  logic [LANES*DATA_W-1:0]   data_q, data_d;
  logic [LANES-1:0]          mask_q, mask_d;
  logic [2:0]                slot_q, slot_d;
  logic                      fv_q, fv_d, rdy_q, rdy_d;
  logic [2:0]                lane;
  logic                      acc;
  assign lane = seq_mode ? slot_q : in_sel;
  assign acc  = in_valid & rdy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      data_q  <= '0;
      mask_q  <= '0;
      slot_q  <= '0;
      fv_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      rdy_q   <= rdy_d;
    end
  end
  // in_ready is re-asserted every FILL cycle, which also gives the post-reset rise.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    slot_d  = slot_q;
    fv_d    = fv_q;
    rdy_d   = rdy_q;
    if (clr) begin
      state_d = FILL;
      mask_d  = '0;
      slot_d  = '0;
      fv_d    = 1'b0;
      rdy_d   = 1'b1;
    end else if (state_q == FILL) begin
      rdy_d = 1'b1;
      if (acc) begin
        data_d[lane*DATA_W +: DATA_W] = in_data;
        mask_d[lane]                  = 1'b1;
        slot_d                        = seq_mode ? slot_q + 3'd1 : slot_q;
        if (&mask_d) begin
          state_d = HOLD;
          fv_d    = 1'b1;
          rdy_d   = 1'b0;
        end
      end
    end else if (frame_ready) begin
      state_d = FILL;
      mask_d  = '0;
      slot_d  = '0;
      fv_d    = 1'b0;
      rdy_d   = 1'b1;
    end
  end
  assign out_data    = data_q;
  assign lane_mask   = mask_q;
  assign slot        = slot_q;
  assign frame_valid = fv_q;
  assign in_ready    = rdy_q;
endmodule

// File: tb/tb_demux_1to8_frame.sv
// tb_demux_1to8_frame: directed scenarios plus random traffic checked against
// a lane-array reference model of the frame demultiplexer.
module tb_demux_1to8_frame;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, seq_mode = 1'b0, clr = 1'b0, frame_ready = 1'b0;
  logic [2:0]  in_data = '0, in_sel = '0;
  logic        in_ready, frame_valid;
  logic [23:0] out_data;
  logic [7:0]  lane_mask;
  logic [2:0]  slot;
  int          n_cmp = 0, n_bad = 0;
  logic [2:0]  m_lane [8];
  logic [7:0]  m_mask;
  int          m_slot;
  logic        m_fv, m_rdy;

  demux_1to8_frame dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .seq_mode(seq_mode), .clr(clr),
    .out_data(out_data), .lane_mask(lane_mask), .slot(slot),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_data();
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[k*3 +: 3] = m_lane[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_lane[k] = '0;
    m_mask = '0; m_slot = 0; m_fv = 1'b0; m_rdy = 1'b0;
  endtask

  // Advances one clock and applies the behavioural rules to the model.
  task automatic tick();
    int lane;
    @(posedge clk);
    if (rst_n) begin
      if (clr) begin
        m_mask = '0; m_slot = 0; m_fv = 1'b0; m_rdy = 1'b1;
      end else if (!m_fv) begin
        if (in_valid && m_rdy) begin
          lane = seq_mode ? m_slot : int'(in_sel);
          m_lane[lane] = in_data;
          m_mask[lane] = 1'b1;
          if (seq_mode) m_slot = (m_slot + 1) % 8;
        end
        m_fv  = (m_mask == 8'hFF);
        m_rdy = !m_fv;
      end else if (frame_ready) begin
        m_mask = '0; m_slot = 0; m_fv = 1'b0; m_rdy = 1'b1;
      end
    end
    #1;
  endtask

  task automatic beat(input logic sq, input logic [2:0] sel, input logic [2:0] d);
    in_valid = 1'b1; seq_mode = sq; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({out_data, lane_mask, slot, frame_valid, in_ready} !== '0) begin
      n_bad++; $display("FAIL reset_vals got %h/%h/%0d/%b/%b want all zero", out_data, lane_mask, slot, frame_valid, in_ready);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rise got %b want 1", in_ready); end
  endtask

  task automatic test_seq_fill();
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 3'd0, 3'(i));
      if (i == 6) begin
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL seq_early_fv got %b want 0", frame_valid); end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL seq_fv got %b want 1", frame_valid); end
    n_cmp++; if (out_data !== 24'o76543210) begin n_bad++; $display("FAIL seq_data got %o want 76543210", out_data); end
    n_cmp++; if (slot !== 3'd0 || lane_mask !== 8'hFF) begin n_bad++; $display("FAIL seq_slot_mask got %0d/%h want 0/ff", slot, lane_mask); end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; in_data = 3'd1; seq_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (in_ready !== 1'b0 || frame_valid !== 1'b1 || out_data !== 24'o76543210) begin
        n_bad++; $display("FAIL hold_frozen got rdy=%b fv=%b data=%o want 0/1/76543210", in_ready, frame_valid, out_data);
      end
    end
    ack();
    in_valid = 1'b0;
    n_cmp++; if (lane_mask !== 8'h00 || in_ready !== 1'b1 || frame_valid !== 1'b0 || slot !== 3'd0) begin
      n_bad++; $display("FAIL hold_release got mask=%h rdy=%b fv=%b slot=%0d want 00/1/0/0", lane_mask, in_ready, frame_valid, slot);
    end
    n_cmp++; if (out_data !== 24'o76543210) begin n_bad++; $display("FAIL hold_retain got %o want 76543210", out_data); end
  endtask

  task automatic test_addr_reverse();
    for (int i = 0; i < 8; i++) beat(1'b0, 3'(7 - i), 3'(i + 1));
    n_cmp++; if (frame_valid !== 1'b1 || out_data !== 24'o12345670) begin
      n_bad++; $display("FAIL addr_rev got fv=%b data=%o want 1/12345670", frame_valid, out_data);
    end
    ack();
  endtask

  task automatic test_overwrite();
    beat(1'b0, 3'd2, 3'd5); beat(1'b0, 3'd2, 3'd6); beat(1'b0, 3'd2, 3'd7);
    beat(1'b0, 3'd0, 3'd0); beat(1'b0, 3'd1, 3'd1);
    for (int k = 3; k < 7; k++) beat(1'b0, 3'(k), 3'(k));
    n_cmp++; if (frame_valid !== 1'b0 || lane_mask !== 8'h7F) begin
      n_bad++; $display("FAIL ovw_partial got fv=%b mask=%h want 0/7f", frame_valid, lane_mask);
    end
    beat(1'b0, 3'd7, 3'd7);
    n_cmp++; if (frame_valid !== 1'b1 || out_data !== 24'o76543710) begin
      n_bad++; $display("FAIL ovw_frame got fv=%b data=%o want 1/76543710", frame_valid, out_data);
    end
    ack();
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd0, 3'(i + 4));
    clr = 1'b1; in_valid = 1'b1; seq_mode = 1'b1; in_data = 3'd1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    n_cmp++; if (lane_mask !== 8'h00 || slot !== 3'd0 || in_ready !== 1'b1 || frame_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_state got mask=%h slot=%0d rdy=%b fv=%b want 00/0/1/0", lane_mask, slot, in_ready, frame_valid);
    end
    n_cmp++; if (out_data !== 24'o76547654) begin n_bad++; $display("FAIL clr_data got %o want 76547654", out_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) beat(1'b1, 3'd0, 3'(i + 1));
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({out_data, lane_mask, slot, frame_valid, in_ready} !== '0) begin
      n_bad++; $display("FAIL async_reset got %o/%h/%0d/%b/%b want all zero", out_data, lane_mask, slot, frame_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ready got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom % 4) != 0;
      seq_mode    = ($urandom % 3) != 0;
      in_sel      = 3'($urandom);
      in_data     = 3'($urandom);
      clr         = ($urandom % 25) == 0;
      frame_ready = ($urandom % 3) == 0;
      tick();
      n_cmp++; if (out_data !== exp_data()) begin n_bad++; $display("FAIL rnd_data c=%0d got %o want %o", c, out_data, exp_data()); end
      n_cmp++; if (lane_mask !== m_mask) begin n_bad++; $display("FAIL rnd_mask c=%0d got %h want %h", c, lane_mask, m_mask); end
      n_cmp++; if (slot !== 3'(m_slot)) begin n_bad++; $display("FAIL rnd_slot c=%0d got %0d want %0d", c, slot, m_slot); end
      n_cmp++; if (frame_valid !== m_fv || in_ready !== m_rdy) begin
        n_bad++; $display("FAIL rnd_hs c=%0d got fv=%b rdy=%b want %b/%b", c, frame_valid, in_ready, m_fv, m_rdy);
      end
    end
    in_valid = 1'b0; clr = 1'b0; frame_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq_fill();
    test_hold();
    test_addr_reverse();
    test_overwrite();
    test_clr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
